tipi_link_master: RTL and testbench

Clock-domain-local master for the TIPI four-wire byte link: it plays the Raspberry Pi side of the link so a soft core or the self-test harness can exchange bytes with the TIPI peripheral without external hardware. Each command is turned into a timed sequence of link clocks, shift cycles and one latch cycle. The block writes the RD/RC latches, reads the TD/TC latches, and returns read data through a valid/ready command and response interface.

---
 rtl/tipi_link_master_if.sv | 35 +++
 rtl/tipi_link_master.sv | 230 +++++++++++++++++++++++
 tb/tb_tipi_link_master.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tipi_link_master_if.sv
// -----------------------------------------------------------------------------
// tipi_link_master_if
//
// Command/response bundle between a requester (soft core, self-test harness)
// and tipi_link_master.
//
//   cmd_valid  requester -> master  command offered
//   cmd_ready  master -> requester  command accepted when valid && ready
//   cmd_op     requester -> master  [0:1] 00 wr RD, 01 wr RC, 10 rd TD, 11 rd TC
//   cmd_data   requester -> master  [0:7] write byte, bit 0 = MSB (sent first)
//   rsp_valid  master -> requester  one-cycle completion pulse
//   rsp_data   master -> requester  [0:7] read byte, 00 for writes and aborts
//   rsp_err    master -> requester  transfer aborted by link reset
//
// Modports: master = requester side, slave = the link master block itself.
// -----------------------------------------------------------------------------
interface tipi_link_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [0:1] cmd_op;
  logic [0:7] cmd_data;
  logic       rsp_valid;
  logic [0:7] rsp_data;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/tipi_link_master.sv
// -----------------------------------------------------------------------------
// tipi_link_master
//
// Plays the Raspberry Pi side of the TIPI four-wire byte link. Each accepted
// command becomes nine slots (one LOW phase then one HIGH phase of r_clk each,
// HALF_PERIOD clk cycles per phase). Writes shift the byte MSB first in slots
// 0..7 and latch in slot 8. Reads latch in slot 0, shift in slots 1..8 and
// need one trailing LOW phase so the last returned bit can be sampled.
//
// Parameters
//   HALF_PERIOD  clk cycles per r_clk phase, legal 6..255 (below 6 the
//                peripheral's synchroniser cannot keep up).
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   link_reset   peripheral held in reset: aborts and blocks transfers
//   cmd          command/response bundle (slave side)
//   busy         transfer in progress (LOW/HIGH phases)
//   r_clk, r_le, r_rt, r_dc, r_dout   registered link drive signals
//   r_din        link return data
// -----------------------------------------------------------------------------
module tipi_link_master #(
  parameter int HALF_PERIOD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 link_reset,
  tipi_link_master_if.slave    cmd,
  output logic                 busy,
  output logic                 r_clk,
  output logic                 r_le,
  output logic                 r_rt,
  output logic                 r_dc,
  output logic                 r_dout,
  input  logic                 r_din
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [3:0] SLOT_LAST  = 4'd8;
  // Reads reuse the slot counter value 9 to mark the trailing LOW phase.
  localparam logic [3:0] SLOT_TAIL  = 4'd9;
  // First LOW phase whose end carries a read bit (follows slot 1's HIGH).
  localparam logic [3:0] SLOT_FIRST_SAMPLE = 4'd2;

  state_t     state_reg, state_next;
  logic [3:0] slot_reg, slot_next;
  logic [7:0] phase_reg;
  logic [0:1] op_reg;
  logic [0:7] data_reg;
  logic [0:7] shift_reg;
  logic       err_reg;

  logic       r_clk_next, r_le_next, r_rt_next, r_dc_next, r_dout_next;
  logic       ready_int;
  logic       accept;
  logic       in_xfer;
  logic       phase_end;
  logic       is_read;
  logic       abort;
  logic       sample;
  logic       enter_low;
  logic [0:1] op_eff;
  logic [0:7] data_eff;

  assign ready_int = (state_reg == S_IDLE) && !link_reset && !reset;
  assign accept    = cmd.cmd_valid && ready_int;
  assign in_xfer   = (state_reg == S_LOW) || (state_reg == S_HIGH);
  assign phase_end = (phase_reg == PHASE_LAST);
  assign is_read   = op_reg[0];
  assign abort     = in_xfer && link_reset;
  // r_din is taken on the last cycle of each LOW phase that follows a read
  // shift slot's HIGH phase, i.e. 2*HALF_PERIOD-1 cycles after r_clk rose.
  assign sample    = (state_reg == S_LOW) && phase_end && is_read &&
                     (slot_reg >= SLOT_FIRST_SAMPLE) && !link_reset;
  assign enter_low = (state_next == S_LOW) && (state_reg != S_LOW);

  // On the acceptance edge the captured registers are not loaded yet, so the
  // slot 0 drive values come straight from the command inputs.
  assign op_eff   = (state_reg == S_IDLE) ? cmd.cmd_op   : op_reg;
  assign data_eff = (state_reg == S_IDLE) ? cmd.cmd_data : data_reg;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      slot_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_LOW;
          slot_next  = 4'd0;
        end
      end
      S_LOW: begin
        if (link_reset) begin
          state_next = S_DONE;
        end else if (phase_end) begin
          state_next = (slot_reg == SLOT_TAIL) ? S_DONE : S_HIGH;
        end
      end
      S_HIGH: begin
        if (link_reset) begin
          state_next = S_DONE;
        end else if (phase_end) begin
          if (!is_read && (slot_reg == SLOT_LAST)) begin
            state_next = S_DONE;
          end else begin
            // For reads, slot 8 HIGH moves on to the trailing LOW (slot 9).
            state_next = S_LOW;
            slot_next  = slot_reg + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: handshake outputs and next values of the link drive
  // registers. Drive values are only recomputed when a LOW phase is entered
  // and are held through the following HIGH phase; IDLE and DONE drive 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd.cmd_ready = ready_int;
    cmd.rsp_valid = (state_reg == S_DONE);
    cmd.rsp_err   = (state_reg == S_DONE) && err_reg;
    cmd.rsp_data  = (state_reg == S_DONE) ? shift_reg : 8'h00;
    busy          = in_xfer;

    r_clk_next  = 1'b0;
    r_le_next   = 1'b0;
    r_rt_next   = 1'b0;
    r_dc_next   = 1'b0;
    r_dout_next = 1'b0;

    if (enter_low) begin
      if (op_eff[0]) begin
        // Read: latch slot 0, shift slots 1..8 and the trailing LOW.
        r_rt_next = 1'b1;
        if (slot_next == 4'd0) begin
          r_le_next = 1'b1;
          r_dc_next = !op_eff[1];
        end
      end else if (slot_next == SLOT_LAST) begin
        // Write latch slot.
        r_le_next = 1'b1;
        r_dc_next = !op_eff[1];
      end else begin
        r_dout_next = data_eff[slot_next[2:0]];
      end
    end else if ((state_next == S_LOW) || (state_next == S_HIGH)) begin
      r_clk_next  = (state_next == S_HIGH);
      r_le_next   = r_le;
      r_rt_next   = r_rt;
      r_dc_next   = r_dc;
      r_dout_next = r_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: phase counter, command capture, read shifter, drive registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= 8'd0;
      op_reg    <= 2'b00;
      data_reg  <= 8'h00;
      shift_reg <= 8'h00;
      err_reg   <= 1'b0;
      r_clk     <= 1'b0;
      r_le      <= 1'b0;
      r_rt      <= 1'b0;
      r_dc      <= 1'b0;
      r_dout    <= 1'b0;
    end else begin
      // Restart the phase count on every state change.
      if (in_xfer && (state_next == state_reg)) begin
        phase_reg <= phase_reg + 8'd1;
      end else begin
        phase_reg <= 8'd0;
      end

      if (accept) begin
        op_reg    <= cmd.cmd_op;
        data_reg  <= cmd.cmd_data;
        shift_reg <= 8'h00;
        err_reg   <= 1'b0;
      end else if (abort) begin
        err_reg   <= 1'b1;
        shift_reg <= 8'h00;
      end else if (sample) begin
        // First sample ends up in bit 0 (MSB) after eight shifts.
        shift_reg <= {shift_reg[1:7], r_din};
      end

      r_clk  <= r_clk_next;
      r_le   <= r_le_next;
      r_rt   <= r_rt_next;
      r_dc   <= r_dc_next;
      r_dout <= r_dout_next;
    end
  end

endmodule

// File: tb/tb_tipi_link_master.sv
// -----------------------------------------------------------------------------
// tb_tipi_link_master
//
// Two masters (HALF_PERIOD 8 and 6) each looped back to a small behavioural
// TIPI peripheral (RD/RC receive latches, TD/TC transmit latches). Expected
// responses are queued when a command is issued and popped on completion.
// -----------------------------------------------------------------------------
module tb_tipi_link_master;

  localparam int LIMIT = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       link_reset [2];
  logic       cmd_valid  [2];
  logic [0:1] cmd_op     [2];
  logic [0:7] cmd_data   [2];
  wire        cmd_ready  [2];
  wire        rsp_valid  [2];
  wire  [0:7] rsp_data   [2];
  wire        rsp_err    [2];
  wire        busy       [2];
  wire        r_clk      [2];
  wire        r_le       [2];
  wire        r_rt       [2];
  wire        r_dc       [2];
  wire        r_dout     [2];
  logic       r_din      [2];

  // Peripheral model state
  logic [7:0] rd    [2];
  logic [7:0] rc    [2];
  logic [7:0] td    [2];
  logic [7:0] tc    [2];
  logic [7:0] rx_sr [2];
  logic [7:0] tx_sr [2];
  logic       rclk_prev [2];

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       err;
    logic [0:7] data;
    int         lat;
  } exp_t;
  exp_t sb[$];

  tipi_link_master_if if8 ();
  tipi_link_master_if if6 ();

  assign if8.cmd_valid = cmd_valid[0];
  assign if8.cmd_op    = cmd_op[0];
  assign if8.cmd_data  = cmd_data[0];
  assign cmd_ready[0]  = if8.cmd_ready;
  assign rsp_valid[0]  = if8.rsp_valid;
  assign rsp_data[0]   = if8.rsp_data;
  assign rsp_err[0]    = if8.rsp_err;

  assign if6.cmd_valid = cmd_valid[1];
  assign if6.cmd_op    = cmd_op[1];
  assign if6.cmd_data  = cmd_data[1];
  assign cmd_ready[1]  = if6.cmd_ready;
  assign rsp_valid[1]  = if6.rsp_valid;
  assign rsp_data[1]   = if6.rsp_data;
  assign rsp_err[1]    = if6.rsp_err;

  tipi_link_master #(.HALF_PERIOD(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .link_reset (link_reset[0]),
    .cmd        (if8.slave),
    .busy       (busy[0]),
    .r_clk      (r_clk[0]),
    .r_le       (r_le[0]),
    .r_rt       (r_rt[0]),
    .r_dc       (r_dc[0]),
    .r_dout     (r_dout[0]),
    .r_din      (r_din[0])
  );

  tipi_link_master #(.HALF_PERIOD(6)) dut6 (
    .clk        (clk),
    .reset      (reset),
    .link_reset (link_reset[1]),
    .cmd        (if6.slave),
    .busy       (busy[1]),
    .r_clk      (r_clk[1]),
    .r_le       (r_le[1]),
    .r_rt       (r_rt[1]),
    .r_dc       (r_dc[1]),
    .r_dout     (r_dout[1]),
    .r_din      (r_din[1])
  );

  // Behavioural peripheral: acts one clk after each r_clk rise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rclk_prev[i] <= r_clk[i];
      if (reset) begin
        rd[i]    <= 8'h00;
        rc[i]    <= 8'h00;
        rx_sr[i] <= 8'h00;
        tx_sr[i] <= 8'h00;
        r_din[i] <= 1'b0;
      end else if (link_reset[i]) begin
        rx_sr[i] <= 8'h00;
        tx_sr[i] <= 8'h00;
        r_din[i] <= 1'b0;
      end else if (r_clk[i] && !rclk_prev[i]) begin
        if (r_le[i]) begin
          if (r_rt[i]) tx_sr[i] <= r_dc[i] ? td[i] : tc[i];
          else if (r_dc[i]) rd[i] <= rx_sr[i];
          else rc[i] <= rx_sr[i];
        end else if (r_rt[i]) begin
          r_din[i] <= tx_sr[i][7];
          tx_sr[i] <= {tx_sr[i][6:0], 1'b0};
        end else begin
          rx_sr[i] <= {rx_sr[i][6:0], r_dout[i]};
        end
      end
    end
  end

  // Issue one command on master i and follow it to its response, measuring
  // latency, r_clk rise spacing and drive changes while r_clk is high.
  task automatic do_cmd(input int i, input logic [0:1] op, input logic [0:7] data,
                        output int wait_cyc, output int lat, output logic got_err,
                        output logic [0:7] got_data, output int rises,
                        output int min_per, output int max_per, output int stab_viol);
    logic [3:0] prev_drive;
    logic       prev_clk;
    int         last_rise;
    wait_cyc = 0;
    while (!cmd_ready[i] && wait_cyc < LIMIT) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    cmd_valid[i] = 1'b1;
    cmd_op[i]    = op;
    cmd_data[i]  = data;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    cmd_op[i]    = ~op;
    cmd_data[i]  = ~data;
    lat       = 1;
    rises     = 0;
    min_per   = 1000;
    max_per   = 0;
    stab_viol = 0;
    last_rise = -1;
    prev_drive = {r_le[i], r_rt[i], r_dc[i], r_dout[i]};
    prev_clk   = r_clk[i];
    while (!rsp_valid[i] && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
      if (r_clk[i] && !prev_clk) begin
        rises++;
        if (last_rise >= 0) begin
          if (lat - last_rise < min_per) min_per = lat - last_rise;
          if (lat - last_rise > max_per) max_per = lat - last_rise;
        end
        last_rise = lat;
      end
      if (r_clk[i] && ({r_le[i], r_rt[i], r_dc[i], r_dout[i]} !== prev_drive)) stab_viol++;
      prev_drive = {r_le[i], r_rt[i], r_dc[i], r_dout[i]};
      prev_clk   = r_clk[i];
    end
    got_err  = rsp_err[i];
    got_data = rsp_data[i];
    $display("[TB] inst %0d op %b data %h -> valid %b err %b rsp %h latency %0d",
             i, op, data, rsp_valid[i], got_err, got_data, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (cmd_ready[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_during: got %b want 0", cmd_ready[0]);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (cmd_ready[0] !== 1'b1 || cmd_ready[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_after: got %b/%b want 1/1", cmd_ready[0], cmd_ready[1]);
    end
    tests_run++;
    if ({rsp_valid[0], rsp_err[0], busy[0]} !== 3'b000 || rsp_data[0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_rsp: got valid/err/busy %b%b%b data %h want 000 00",
               rsp_valid[0], rsp_err[0], busy[0], rsp_data[0]);
    end
    tests_run++;
    if ({r_clk[0], r_le[0], r_rt[0], r_dc[0], r_dout[0]} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_link: got %b%b%b%b%b want 00000",
               r_clk[0], r_le[0], r_rt[0], r_dc[0], r_dout[0]);
    end
  endtask

  task automatic test_write_rd();
    int w, lat, rs, mn, mx, sv;
    logic e;
    logic [0:7] d;
    exp_t x;
    sb.push_back('{err: 1'b0, data: 8'h00, lat: 145});
    do_cmd(0, 2'b00, 8'hA5, w, lat, e, d, rs, mn, mx, sv);
    x = sb.pop_front();
    tests_run++;
    if (lat !== x.lat) begin
      tests_failed++;
      $display("FAIL write_latency: got %0d want %0d", lat, x.lat);
    end
    tests_run++;
    if (e !== x.err || d !== x.data) begin
      tests_failed++;
      $display("FAIL write_rsp: got err %b data %h want err %b data %h", e, d, x.err, x.data);
    end
    tests_run++;
    if (rd[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL write_rd_reg: got %h want a5", rd[0]);
    end
    tests_run++;
    if (rs !== 9 || mn !== 16 || mx !== 16 || sv !== 0) begin
      tests_failed++;
      $display("FAIL write_clocking: got rises %0d period %0d..%0d unstable %0d want 9 16..16 0",
               rs, mn, mx, sv);
    end
  endtask

  task automatic test_back_to_back();
    int w, lat, rs, mn, mx, sv;
    logic e;
    logic [0:7] d;
    exp_t x;
    sb.push_back('{err: 1'b0, data: 8'h00, lat: 145});
    do_cmd(0, 2'b01, 8'h3C, w, lat, e, d, rs, mn, mx, sv);
    x = sb.pop_front();
    tests_run++;
    if (lat !== x.lat || e !== x.err || d !== x.data) begin
      tests_failed++;
      $display("FAIL b2b_first: got lat %0d err %b data %h want %0d %b %h",
               lat, e, d, x.lat, x.err, x.data);
    end
    sb.push_back('{err: 1'b0, data: 8'h00, lat: 145});
    do_cmd(0, 2'b00, 8'hC3, w, lat, e, d, rs, mn, mx, sv);
    x = sb.pop_front();
    tests_run++;
    if (w !== 1) begin
      tests_failed++;
      $display("FAIL b2b_accept_gap: got %0d cycles after response want 1", w);
    end
    tests_run++;
    if (lat !== x.lat || e !== x.err || d !== x.data) begin
      tests_failed++;
      $display("FAIL b2b_second: got lat %0d err %b data %h want %0d %b %h",
               lat, e, d, x.lat, x.err, x.data);
    end
    tests_run++;
    if (rc[0] !== 8'h3C || rd[0] !== 8'hC3) begin
      tests_failed++;
      $display("FAIL b2b_regs: got rc %h rd %h want 3c c3", rc[0], rd[0]);
    end
  endtask

  task automatic test_read();
    int w, lat, rs, mn, mx, sv;
    logic e;
    logic [0:7] d;
    exp_t x;
    sb.push_back('{err: 1'b0, data: 8'hAB, lat: 153});
    do_cmd(0, 2'b10, 8'h00, w, lat, e, d, rs, mn, mx, sv);
    x = sb.pop_front();
    tests_run++;
    if (lat !== x.lat || e !== x.err || d !== x.data) begin
      tests_failed++;
      $display("FAIL read_td: got lat %0d err %b data %h want %0d %b %h",
               lat, e, d, x.lat, x.err, x.data);
    end
    tc[0] = 8'h5A;
    sb.push_back('{err: 1'b0, data: 8'h5A, lat: 153});
    do_cmd(0, 2'b11, 8'hFF, w, lat, e, d, rs, mn, mx, sv);
    x = sb.pop_front();
    tests_run++;
    if (lat !== x.lat || e !== x.err || d !== x.data) begin
      tests_failed++;
      $display("FAIL read_tc: got lat %0d err %b data %h want %0d %b %h",
               lat, e, d, x.lat, x.err, x.data);
    end
  endtask

  task automatic test_link_reset_abort();
    int n;
    exp_t x;
    n = 0;
    while (!cmd_ready[0] && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    sb.push_back('{err: 1'b1, data: 8'h00, lat: 0});
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = 2'b00;
    cmd_data[0]  = 8'h77;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    // Slot 4 LOW spans cycles 65..72 after acceptance; stop in the middle.
    repeat (69) @(posedge clk);
    #1;
    tests_run++;
    if (busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_busy_before: got %b want 1", busy[0]);
    end
    link_reset[0] = 1'b1;
    @(posedge clk); #1;
    x = sb.pop_front();
    tests_run++;
    if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== x.err || rsp_data[0] !== x.data) begin
      tests_failed++;
      $display("FAIL abort_rsp: got valid %b err %b data %h want 1 %b %h",
               rsp_valid[0], rsp_err[0], rsp_data[0], x.err, x.data);
    end
    $display("[TB] inst 0 op 00 data 77 -> aborted, err %b rsp %h", rsp_err[0], rsp_data[0]);
    tests_run++;
    if ({r_clk[0], r_le[0], r_rt[0], r_dc[0], r_dout[0]} !== 5'b0) begin
      tests_failed++;
      $display("FAIL abort_link: got %b%b%b%b%b want 00000",
               r_clk[0], r_le[0], r_rt[0], r_dc[0], r_dout[0]);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (cmd_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_hold: got ready %b valid %b want 0 0", cmd_ready[0], rsp_valid[0]);
    end
    link_reset[0] = 1'b0;
    #1;
    tests_run++;
    if (cmd_ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_release: got ready %b want 1", cmd_ready[0]);
    end
    tests_run++;
    if (rd[0] !== 8'hC3) begin
      tests_failed++;
      $display("FAIL abort_rd_kept: got %h want c3", rd[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    int n, seen;
    int w, lat, rs, mn, mx, sv;
    logic e;
    logic [0:7] d;
    exp_t x;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = 2'b10;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({rsp_valid[0], rsp_err[0], busy[0], cmd_ready[0]} !== 4'b0000 || rsp_data[0] !== 8'h00 ||
        {r_clk[0], r_le[0], r_rt[0], r_dc[0], r_dout[0]} !== 5'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got valid/err/busy/ready %b%b%b%b data %h link %b%b%b%b%b want 0000 00 00000",
               rsp_valid[0], rsp_err[0], busy[0], cmd_ready[0], rsp_data[0],
               r_clk[0], r_le[0], r_rt[0], r_dc[0], r_dout[0]);
    end
    reset = 1'b0;
    tc[0] = 8'h5A;
    seen = 0;
    for (n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_rsp: got %0d responses want 0", seen);
    end
    sb.push_back('{err: 1'b0, data: 8'hAB, lat: 153});
    do_cmd(0, 2'b10, 8'h00, w, lat, e, d, rs, mn, mx, sv);
    x = sb.pop_front();
    tests_run++;
    if (lat !== x.lat || e !== x.err || d !== x.data) begin
      tests_failed++;
      $display("FAIL midreset_next_read: got lat %0d err %b data %h want %0d %b %h",
               lat, e, d, x.lat, x.err, x.data);
    end
  endtask

  task automatic test_hp6();
    int w, lat, rs, mn, mx, sv;
    logic e;
    logic [0:7] d;
    exp_t x;
    sb.push_back('{err: 1'b0, data: 8'hAB, lat: 115});
    do_cmd(1, 2'b10, 8'h00, w, lat, e, d, rs, mn, mx, sv);
    x = sb.pop_front();
    tests_run++;
    if (lat !== x.lat || e !== x.err || d !== x.data) begin
      tests_failed++;
      $display("FAIL hp6_read: got lat %0d err %b data %h want %0d %b %h",
               lat, e, d, x.lat, x.err, x.data);
    end
    tests_run++;
    if (rs !== 9 || mn !== 12 || mx !== 12 || sv !== 0) begin
      tests_failed++;
      $display("FAIL hp6_clocking: got rises %0d period %0d..%0d unstable %0d want 9 12..12 0",
               rs, mn, mx, sv);
    end
    sb.push_back('{err: 1'b0, data: 8'h00, lat: 109});
    do_cmd(1, 2'b01, 8'h96, w, lat, e, d, rs, mn, mx, sv);
    x = sb.pop_front();
    tests_run++;
    if (lat !== x.lat || e !== x.err || d !== x.data || rc[1] !== 8'h96) begin
      tests_failed++;
      $display("FAIL hp6_write_rc: got lat %0d err %b data %h rc %h want %0d %b %h 96",
               lat, e, d, rc[1], x.lat, x.err, x.data);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      link_reset[i] = 1'b0;
      cmd_valid[i]  = 1'b0;
      cmd_op[i]     = 2'b00;
      cmd_data[i]   = 8'h00;
      td[i]         = 8'hAB;
      tc[i]         = 8'h00;
    end
    test_reset();
    test_write_rd();
    test_back_to_back();
    test_read();
    test_link_reset_abort();
    test_reset_mid_read();
    test_hp6();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
